// File: rtl/nand_latch_sequencer.sv
// ONFI command/address latch sequencer: one start issues cmd0, up to MAX_ADDR
// address bytes and an optional confirm command, each as a SETUP/WP/HOLD beat.
module nand_latch_sequencer #(
    parameter int DQ_W     = 8,
    parameter int MAX_ADDR = 5,
    parameter int T_SETUP  = 1,
    parameter int T_WP     = 2,
    parameter int T_WH     = 2,
    localparam int CNT_W   = $clog2(MAX_ADDR + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DQ_W-1:0]          cmd0,
    input  logic [MAX_ADDR*DQ_W-1:0] addr,
    input  logic [CNT_W-1:0]         addr_cnt,
    input  logic                     cmd1_en,
    input  logic [DQ_W-1:0]          cmd1,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     cle,
    output logic                     ale,
    output logic                     we_n,
    output logic [DQ_W-1:0]          dq_out,
    output logic                     dq_oe
);
    localparam int PH_W   = 8;
    localparam int BEAT_W = $clog2(MAX_ADDR + 3);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WP, S_HOLD} state_t;

    state_t                   state_q, state_d;
    logic [PH_W-1:0]          phase_q, phase_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [DQ_W-1:0]          cmd0_q, cmd0_d, cmd1_q, cmd1_d;
    logic                     cmd1_en_q, cmd1_en_d;
    logic [MAX_ADDR*DQ_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]         addr_cnt_q, addr_cnt_d;
    logic                     busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                     cle_q, cle_d, ale_q, ale_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
    logic [DQ_W-1:0]          dq_out_q, dq_out_d;
    logic [BEAT_W-1:0]        last_beat;
    logic                     beat_is_cmd;
    logic [DQ_W-1:0]          beat_byte;

    assign last_beat = BEAT_W'(addr_cnt_q) + BEAT_W'(cmd1_en_q);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        beat_d     = beat_q;
        cmd0_d     = cmd0_q;
        cmd1_d     = cmd1_q;
        cmd1_en_d  = cmd1_en_q;
        addr_d     = addr_q;
        addr_cnt_d = addr_cnt_q;
        err_d      = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (addr_cnt > CNT_W'(MAX_ADDR)) begin
                        err_d = 1'b1;
                    end else begin
                        cmd0_d     = cmd0;
                        cmd1_d     = cmd1;
                        cmd1_en_d  = cmd1_en;
                        addr_d     = addr;
                        addr_cnt_d = addr_cnt;
                        state_d    = S_SETUP;
                        phase_d    = '0;
                        beat_d     = '0;
                    end
                end
            end
            S_SETUP: begin
                if (phase_q == PH_W'(T_SETUP - 1)) begin
                    state_d = S_WP;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_WP: begin
                if (phase_q == PH_W'(T_WP - 1)) begin
                    state_d = S_HOLD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_HOLD: begin
                if (phase_q == PH_W'(T_WH - 1)) begin
                    phase_d = '0;
                    if (beat_q == last_beat) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pad outputs are derived from the next state so they land registered with it.
        beat_is_cmd = (beat_d == '0) || (beat_d > BEAT_W'(addr_cnt_d));
        beat_byte   = (beat_d == '0) ? cmd0_d : cmd1_d;
        for (int i = 0; i < MAX_ADDR; i++) begin
            if (beat_d == BEAT_W'(i + 1) && !beat_is_cmd) begin
                beat_byte = addr_d[i*DQ_W +: DQ_W];
            end
        end
        busy_d   = (state_d != S_IDLE);
        cle_d    = busy_d && beat_is_cmd;
        ale_d    = busy_d && !beat_is_cmd;
        we_n_d   = (state_d != S_WP);
        dq_oe_d  = busy_d;
        dq_out_d = busy_d ? beat_byte : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            beat_q     <= '0;
            cmd0_q     <= '0;
            cmd1_q     <= '0;
            cmd1_en_q  <= 1'b0;
            addr_q     <= '0;
            addr_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cle_q      <= 1'b0;
            ale_q      <= 1'b0;
            we_n_q     <= 1'b1;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            beat_q     <= beat_d;
            cmd0_q     <= cmd0_d;
            cmd1_q     <= cmd1_d;
            cmd1_en_q  <= cmd1_en_d;
            addr_q     <= addr_d;
            addr_cnt_q <= addr_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cle_q      <= cle_d;
            ale_q      <= ale_d;
            we_n_q     <= we_n_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign cle    = cle_q;
    assign ale    = ale_q;
    assign we_n   = we_n_q;
    assign dq_out = dq_out_q;
    assign dq_oe  = dq_oe_q;
endmodule

// File: tb/tb_nand_latch_sequencer.sv
// Directed bench for nand_latch_sequencer: default 8-bit instance plus a
// 16-bit instance with non-default timing.
module tb_nand_latch_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit DUT, default parameters (L = 5, WE# low at beat cycles 1..2)
    logic        start;
    logic [7:0]  cmd0, cmd1, dq_out;
    logic [39:0] addr;
    logic [2:0]  addr_cnt;
    logic        cmd1_en, busy, done, err, cle, ale, we_n, dq_oe;

    nand_latch_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .cmd0(cmd0), .addr(addr),
        .addr_cnt(addr_cnt), .cmd1_en(cmd1_en), .cmd1(cmd1),
        .busy(busy), .done(done), .err(err), .cle(cle), .ale(ale),
        .we_n(we_n), .dq_out(dq_out), .dq_oe(dq_oe)
    );

    // 16-bit DUT (L = 6, WE# low at beat cycles 2..4)
    logic        w_start;
    logic [15:0] w_cmd0, w_cmd1, w_dq_out;
    logic [79:0] w_addr;
    logic [2:0]  w_addr_cnt;
    logic        w_cmd1_en, w_busy, w_done, w_err, w_cle, w_ale, w_we_n, w_dq_oe;

    nand_latch_sequencer #(.DQ_W(16), .T_SETUP(2), .T_WP(3), .T_WH(1)) u_dut16 (
        .clk(clk), .rst(rst), .start(w_start), .cmd0(w_cmd0), .addr(w_addr),
        .addr_cnt(w_addr_cnt), .cmd1_en(w_cmd1_en), .cmd1(w_cmd1),
        .busy(w_busy), .done(w_done), .err(w_err), .cle(w_cle), .ale(w_ale),
        .we_n(w_we_n), .dq_out(w_dq_out), .dq_oe(w_dq_oe)
    );

    typedef struct {
        logic [7:0]  cmd0;
        logic [39:0] addr;
        logic [2:0]  cnt;
        logic        c1en;
        logic [7:0]  cmd1;
        int          beats;
        logic [55:0] dq;      // expected byte of beat b at [b*8 +: 8]
        logic [6:0]  is_cmd;  // bit b set when beat b is a command beat
    } vec_t;

    vec_t tbl[4];
    int   n_cmp = 0;
    int   n_fail = 0;

    localparam logic [22:0] IDLE_V = {7'b0000010, 16'h0000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] pk(input logic b, input logic d, input logic e,
                                       input logic c, input logic a, input logic w,
                                       input logic o, input logic [15:0] q);
        return {b, d, e, c, a, w, o, q};
    endfunction

    function automatic logic [22:0] act8();
        return pk(busy, done, err, cle, ale, we_n, dq_oe, {8'h00, dq_out});
    endfunction

    function automatic logic [22:0] act16();
        return pk(w_busy, w_done, w_err, w_cle, w_ale, w_we_n, w_dq_oe, w_dq_out);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue8(input int v);
        cmd0     = tbl[v].cmd0;
        addr     = tbl[v].addr;
        addr_cnt = tbl[v].cnt;
        cmd1_en  = tbl[v].c1en;
        cmd1     = tbl[v].cmd1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Checks every busy cycle of vector v, then the done cycle. Leaves time in the done cycle.
    task automatic body8(input int v, input bit scramble);
        int   n, b, p, pulses;
        logic prev_we, exp_cmd;
        n = tbl[v].beats * 5;
        pulses = 0;
        prev_we = 1'b1;
        for (int c = 0; c < n; c++) begin
            b = c / 5;
            p = c % 5;
            exp_cmd = tbl[v].is_cmd[b];
            check($sformatf("v%0d_cyc%0d", v, c), 32'(act8()),
                  32'(pk(1'b1, 1'b0, 1'b0, exp_cmd, !exp_cmd, !(p >= 1 && p < 3), 1'b1,
                         {8'h00, tbl[v].dq[b*8 +: 8]})));
            if (prev_we && !we_n) pulses++;
            prev_we = we_n;
            if (scramble) begin
                start    = 1'($urandom_range(0, 1));
                cmd0     = 8'($urandom_range(0, 255));
                cmd1     = 8'($urandom_range(0, 255));
                addr     = {8'($urandom), 32'($urandom)};
                addr_cnt = 3'($urandom_range(0, 7));
                cmd1_en  = 1'($urandom_range(0, 1));
            end
            tick();
        end
        check($sformatf("v%0d_done", v), 32'(act8()), 32'(pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0)));
        check($sformatf("v%0d_we_pulses", v), 32'(pulses), 32'(tbl[v].beats));
        start = 1'b0;
    endtask

    initial begin
        int   b, p;
        logic [15:0] exp_q;
        tbl[0] = '{8'hFF, 40'h0, 3'd0, 1'b0, 8'h00, 1, 56'hFF, 7'b0000001};
        tbl[1] = '{8'h00, 40'h55_44_33_22_11, 3'd5, 1'b1, 8'h30, 7,
                   56'h30_55_44_33_22_11_00, 7'b1000001};
        tbl[2] = '{8'h60, 40'hCC_BB_AA, 3'd3, 1'b1, 8'hD0, 5, 56'hD0_CC_BB_AA_60, 7'b0010001};
        tbl[3] = '{8'h90, 40'h20, 3'd1, 1'b0, 8'h00, 2, 56'h20_90, 7'b0000001};

        rst = 1'b1;
        start = 1'b0; cmd0 = '0; cmd1 = '0; addr = '0; addr_cnt = '0; cmd1_en = 1'b0;
        w_start = 1'b0; w_cmd0 = '0; w_cmd1 = '0; w_addr = '0; w_addr_cnt = '0; w_cmd1_en = 1'b0;
        repeat (3) tick();
        check("reset_state", 32'(act8()), 32'(IDLE_V));
        check("reset_state16", 32'(act16()), 32'(IDLE_V));
        rst = 1'b0;
        tick();
        check("idle_after_reset", 32'(act8()), 32'(IDLE_V));

        for (int v = 0; v < 4; v++) begin
            issue8(v);
            body8(v, 1'b0);
            tick();
            check($sformatf("v%0d_idle_after", v), 32'(act8()), 32'(IDLE_V));
        end

        // Rejected start: too many address cycles
        cmd0 = 8'hAB; addr_cnt = 3'd6; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", 32'(act8()), 32'(pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0)));
        tick();
        check("err_clear", 32'(act8()), 32'(IDLE_V));
        issue8(0);
        body8(0, 1'b0);
        tick();
        check("after_err_idle", 32'(act8()), 32'(IDLE_V));

        // Start pulses and input churn while busy must not disturb the sequence
        issue8(1);
        body8(1, 1'b1);
        tick();
        check("scramble_idle_after", 32'(act8()), 32'(IDLE_V));

        // Start in the done cycle begins the next sequence immediately
        issue8(3);
        body8(3, 1'b0);
        issue8(2);
        body8(2, 1'b0);
        tick();
        check("chain_idle_after", 32'(act8()), 32'(IDLE_V));

        // Reset during WP of beat 2 (address byte 1)
        issue8(1);
        repeat (11) tick();
        check("pre_rst_wp", 32'(act8()), 32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0022)));
        rst = 1'b1;
        tick();
        check("rst_mid_beat", 32'(act8()), 32'(IDLE_V));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_idle%0d", i), 32'(act8()), 32'(IDLE_V));
        end

        // 16-bit instance: two beats of L = 6
        w_cmd0 = 16'h00EF; w_addr = 80'h0090; w_addr_cnt = 3'd1; w_cmd1_en = 1'b0;
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            b = c / 6;
            p = c % 6;
            exp_q = (b == 0) ? 16'h00EF : 16'h0090;
            check($sformatf("w16_cyc%0d", c), 32'(act16()),
                  32'(pk(1'b1, 1'b0, 1'b0, b == 0, b == 1, !(p >= 2 && p < 5), 1'b1, exp_q)));
            tick();
        end
        check("w16_done", 32'(act16()), 32'(pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0)));
        tick();
        check("w16_idle_after", 32'(act16()), 32'(IDLE_V));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
